// File: rtl/dac_spi_rx.sv
// SPI frame receiver: oversamples CS/SCLK/SDI, shifts SDI MSB-first, checks frame length,
// decodes DAC command fields and keeps the last value written per channel.
`timescale 1ns/1ps
module dac_spi_rx #(
  parameter int FRAME_BITS = 16,
  parameter bit SAMPLE_POS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_cs_n,
  input  logic                  spi_sclk,
  input  logic                  spi_sdi,
  output logic                  word_valid,
  output logic [FRAME_BITS-1:0] word_data,
  output logic                  frame_err,
  output logic                  dac_ch,
  output logic                  dac_gain_n,
  output logic                  dac_shdn_n,
  output logic [11:0]           dac_value,
  output logic [11:0]           ch_a_value,
  output logic [11:0]           ch_b_value,
  output logic [7:0]            frame_cnt,
  output logic                  busy
);

  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_GOOD = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state_q, state_d;

  logic cs_s1, cs_s2, cs_d;
  logic sclk_s1, sclk_s2, sclk_d;
  logic sdi_s1, sdi_s2;

  logic [FRAME_BITS-1:0] shreg;
  logic [CW-1:0]         bit_cnt;

  logic        cs_fall, cs_rise, sclk_rise, sclk_fall, sample_edge;
  logic        sh_ch, sh_shdn_n;
  logic [11:0] sh_value;

  // CS synchroniser and its history preset high so reset release looks like idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      sdi_s1  <= 1'b0;
      sdi_s2  <= 1'b0;
    end else begin
      cs_s1   <= spi_cs_n;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      sclk_s1 <= spi_sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      sdi_s1  <= spi_sdi;
      sdi_s2  <= sdi_s1;
    end
  end

  assign cs_fall     = cs_d & ~cs_s2;
  assign cs_rise     = ~cs_d & cs_s2;
  assign sclk_rise   = sclk_s2 & ~sclk_d;
  assign sclk_fall   = ~sclk_s2 & sclk_d;
  assign sample_edge = SAMPLE_POS ? sclk_rise : sclk_fall;
  assign busy        = ~cs_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT:   if (cs_rise) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      word_data  <= '0;
      frame_cnt  <= 8'd0;
      ch_a_value <= 12'd0;
      ch_b_value <= 12'd0;
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            shreg   <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          // A sample edge coinciding with the CS rise still lands in the frame.
          if (sample_edge) begin
            shreg <= {shreg[FRAME_BITS-2:0], sdi_s2};
            if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DONE: begin
          if (bit_cnt == CNT_GOOD) begin
            word_data  <= shreg;
            word_valid <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
            if (sh_shdn_n && !sh_ch) ch_a_value <= sh_value;
            if (sh_shdn_n &&  sh_ch) ch_b_value <= sh_value;
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Field decode uses the 16-bit bit positions; bits beyond the frame read as 0.
  for (genvar i = 0; i < 12; i++) begin : g_val
    if (i < FRAME_BITS) begin : g_on
      assign dac_value[i] = word_data[i];
      assign sh_value[i]  = shreg[i];
    end else begin : g_off
      assign dac_value[i] = 1'b0;
      assign sh_value[i]  = 1'b0;
    end
  end

  if (FRAME_BITS > 12) begin : g_shdn_on
    assign dac_shdn_n = word_data[12];
    assign sh_shdn_n  = shreg[12];
  end else begin : g_shdn_off
    assign dac_shdn_n = 1'b0;
    assign sh_shdn_n  = 1'b0;
  end

  if (FRAME_BITS > 13) begin : g_gain_on
    assign dac_gain_n = word_data[13];
  end else begin : g_gain_off
    assign dac_gain_n = 1'b0;
  end

  if (FRAME_BITS > 15) begin : g_ch_on
    assign dac_ch = word_data[15];
    assign sh_ch  = shreg[15];
  end else begin : g_ch_off
    assign dac_ch = 1'b0;
    assign sh_ch  = 1'b0;
  end

endmodule

// File: tb/tb_dac_spi_rx.sv
// Bench for dac_spi_rx: directed SPI frames, expected responses queued at issue time
// and checked by an independent monitor whenever a pulse appears.
`timescale 1ns/1ps
module tb_dac_spi_rx;

  logic        clk = 1'b0;
  logic        rst_n, spi_cs_n, spi_sclk, spi_sdi;
  logic        word_valid, frame_err;
  logic [15:0] word_data;
  logic        dac_ch, dac_gain_n, dac_shdn_n;
  logic [11:0] dac_value, ch_a_value, ch_b_value;
  logic [7:0]  frame_cnt;
  logic        busy;

  always #5 clk = ~clk;

  dac_spi_rx #(.FRAME_BITS(16), .SAMPLE_POS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_sdi(spi_sdi),
    .word_valid(word_valid), .word_data(word_data), .frame_err(frame_err),
    .dac_ch(dac_ch), .dac_gain_n(dac_gain_n), .dac_shdn_n(dac_shdn_n),
    .dac_value(dac_value), .ch_a_value(ch_a_value), .ch_b_value(ch_b_value),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  typedef struct packed {
    logic        is_err;
    logic [15:0] data;
    logic [7:0]  cnt;
    logic [11:0] cha;
    logic [11:0] chb;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_m;
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic is_err, input logic [15:0] data, input logic [7:0] cnt,
                      input logic [11:0] cha, input logic [11:0] chb);
    exp_q.push_back({is_err, data, cnt, cha, chb});
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (word_valid || frame_err)) begin
      chk("pulse_exclusive", 32'(word_valid & frame_err), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, word_valid, frame_err}, 32'd0);
      end else begin
        e_m = exp_q.pop_front();
        chk("pulse_kind", 32'(frame_err), 32'(e_m.is_err));
        chk("word_data", 32'(word_data), 32'(e_m.data));
        chk("dac_ch", 32'(dac_ch), 32'(e_m.data[15]));
        chk("dac_gain_n", 32'(dac_gain_n), 32'(e_m.data[13]));
        chk("dac_shdn_n", 32'(dac_shdn_n), 32'(e_m.data[12]));
        chk("dac_value", 32'(dac_value), 32'(e_m.data[11:0]));
        chk("frame_cnt", 32'(frame_cnt), 32'(e_m.cnt));
        chk("ch_a_value", 32'(ch_a_value), 32'(e_m.cha));
        chk("ch_b_value", 32'(ch_b_value), 32'(e_m.chb));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, got %0d pending expected 0", exp_q.size());
    $fatal(1, "timeout");
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [31:0] v, input int nb, input int hp);
    for (int i = nb - 1; i >= 0; i--) begin
      spi_sdi = v[i];
      clks(hp);
      spi_sclk = 1'b1;
      clks(hp);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] v, input int nb, input int hp);
    spi_cs_n = 1'b0;
    clks(4);
    shift_bits(v, nb, hp);
    clks(4);
    spi_cs_n = 1'b1;
    clks(6);
  endtask

  task automatic idle_toggle();
    for (int i = 0; i < 2; i++) begin
      spi_sdi  = ~spi_sdi;
      spi_sclk = 1'b1;
      clks(3);
      spi_sclk = 1'b0;
      clks(3);
    end
    clks(2);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_word_valid"}, 32'(word_valid), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_word_data"}, 32'(word_data), 32'd0);
    chk({tag, "_dac_fields"}, {dac_ch, dac_gain_n, dac_shdn_n, dac_value}, 32'd0);
    chk({tag, "_ch_a"}, 32'(ch_a_value), 32'd0);
    chk({tag, "_ch_b"}, 32'(ch_b_value), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    spi_sdi  = 1'b0;
    clks(3);
    check_reset_state("por");
    rst_n = 1'b1;
    clks(5);

    // 1: channel A write, SCLK period 10 clk
    push(1'b0, 16'h3ABC, 8'd1, 12'hABC, 12'h000);
    frame(32'h3ABC, 16, 5);
    chk("t1_ch_a_hold", 32'(ch_a_value), 32'h0ABC);

    // 2: channel B write, gain_n set
    push(1'b0, 16'hB123, 8'd2, 12'hABC, 12'h123);
    frame(32'hB123, 16, 5);

    // 3: wrong lengths and an empty frame all report errors and keep the word
    push(1'b1, 16'hB123, 8'd2, 12'hABC, 12'h123);
    frame(32'h1_5A5A, 17, 5);
    push(1'b1, 16'hB123, 8'd2, 12'hABC, 12'h123);
    frame(32'h1234, 15, 5);
    push(1'b1, 16'hB123, 8'd2, 12'hABC, 12'h123);
    spi_cs_n = 1'b0;
    clks(10);
    spi_cs_n = 1'b1;
    clks(6);

    // 4: shutdown command leaves both channel registers alone
    push(1'b0, 16'h2555, 8'd3, 12'hABC, 12'h123);
    frame(32'h2555, 16, 5);

    // 5: reset in the middle of a frame
    chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);
    spi_cs_n = 1'b0;
    clks(4);
    shift_bits(32'h1F, 8, 5);
    chk("t5_busy_mid_frame", 32'(busy), 32'd1);
    rst_n    = 1'b0;
    spi_cs_n = 1'b1;
    clks(3);
    check_reset_state("mid");
    rst_n = 1'b1;
    clks(8);
    push(1'b0, 16'h1FFF, 8'd1, 12'hFFF, 12'h000);
    frame(32'h1FFF, 16, 5);

    // 6: 256 frames at minimum SCLK timing with idle SCLK noise between frames
    rst_n = 1'b0;
    clks(2);
    rst_n = 1'b1;
    clks(5);
    for (int k = 1; k <= 256; k++) begin
      push(1'b0, 16'h3000, 8'(k), 12'h000, 12'h000);
      frame(32'h3000, 16, 3);
      idle_toggle();
    end
    chk("t6_frame_cnt_wrap", 32'(frame_cnt), 32'd0);
    chk("t6_word_data", 32'(word_data), 32'h3000);

    clks(10);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
